vp_window_gen: RTL and testbench
================================

Name: vp_window_gen

Overview:
- Parametrised K x K sliding-window generator for the video-processing pipeline; successor to the fixed 3x3 four-linebuffer controller.
- Sits between pixel capture/colour conversion and any KxK kernel (blur, Sobel, sharpen).
- Generalises kernel size (K), row length and pixel width.
- Adds valid/ready backpressure on both sides, start-of-frame resynchronisation, end-of-row marking, and a fully registered window. Only fully populated windows are emitted ("valid" convolution, no padding).

Parameters:
DW, 12, pixel width in bits
RL, 640, active pixels per row; must satisfy RL >= K
K, 3, window edge; odd, 3..7

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset
i_pixel_data  in  DW  input pixel
i_pixel_valid  in  1  input pixel present
i_sof  in  1  qualifies i_pixel_data as frame pixel (0,0); sampled only on accept
o_pixel_ready  out  1  block can accept input this cycle
o_win_data  out  K*K*DW  window; element (i,j) at [(i*K+j)*DW +: DW]; i = row (0 = oldest row), j = column (0 = oldest column)
o_win_valid  out  1  o_win_data holds a complete window
o_win_last  out  1  window is the last one of its row (centre column RL-1-(K-1)/2)
i_win_ready  in  1  downstream accepts window

Behaviour:
- Reset: synchronous, active-low, on i_rstn; clock i_clk.
- Reset drives o_win_valid = 0, o_win_last = 0, o_win_data = 0, column counter = 0, row counter = 0.
- Line RAM contents are not cleared; row gating makes stale data unobservable.
- Reset asserted mid-frame discards any in-flight window. The next accepted pixel is treated as (0,0), regardless of i_sof.
- Accept rule: accept = i_pixel_valid && o_pixel_ready, where o_pixel_ready = !o_win_valid || i_win_ready. This is combinational with no bubble, so 1 pixel/clk is sustained when i_win_ready = 1.
- Position tracking:
  - col counts 0..RL-1 and wraps to 0 on accept at RL-1.
  - row increments on that wrap and saturates at K-1 (CW = clog2(RL), RW = clog2(K)).
  - i_sof on accept forces the pixel position to (0,0): col' = 1, row' = 0. This holds even mid-row; the partial row is abandoned.
- Line storage:
  - K-1 line RAMs, RL x DW each, with combinational read.
  - On accept at column c, in the same cycle: read lb[0..K-2][c]; write lb[0][c] = pixel; write lb[n][c] = old lb[n-1][c] for n >= 1.
  - Read-before-write is required.
- Window register (K x K x DW):
  - On accept, every row shifts one column toward j = 0.
  - The new column j = K-1 is loaded: row K-1 = pixel; row K-2-n = lb[n][c].
  - No change without accept.
- Output:
  - On accept of pixel (r,c) with r >= K-1 and c >= K-1: o_win_valid <= 1 next cycle, and o_win_last <= (c == RL-1).
  - On accept with the window incomplete: o_win_valid <= 0 (cleared if it was consumed).
  - With no accept and i_win_ready = 1: o_win_valid <= 0.
  - While o_win_valid = 1 and i_win_ready = 0: o_win_data, o_win_valid and o_win_last hold stable and o_pixel_ready = 0.
  - Latency: 1 clk from accept to window valid.
- Rates: windows per row = RL-K+1; first window of a frame follows pixel (K-1,K-1).
- Simultaneous events:
  - i_sof together with the last pixel of a row → sof wins: position becomes (0,0) and row does not increment.
  - Accept together with downstream consumption → new window replaces the old one in the same edge.

Decomposition:
- Package vp_pkg: clog2-derived widths CW and RW; window index helper localparams; K legality check (odd, 3..7, RL >= K) via elaboration-time assertion.
- Sub-module vp_line_ram: single RL x DW RAM, synchronous write, combinational read, no reset. Instantiated K-1 times in a generate loop.
- Top holds the counters, window shift register and output handshake. Target 200-300 lines.

Test Plan:
- K=3, RL=8, pixel = 16*row+col, continuous valid, i_win_ready = 1, first pixel with i_sof → first o_win_valid is 1 clk after pixel (2,2), with data rows {0x00-0x02, 0x10-0x12, 0x20-0x22}.
- Same stimulus → exactly 6 windows per row; o_win_last = 1 on windows whose newest column is 7.
- Hold i_win_ready = 0 for 5 clks mid-row → o_pixel_ready = 0 and o_win_data stable throughout; no pixel lost. Resume → sequence continues with the next column.
- Assert i_sof at pixel (4,3) → no window until new pixel (2,2); stale rows never appear in any window.
- K=5, RL=16, DW=8, random i_pixel_valid gaps → window contents match a software model; 12 windows per row starting at row 4.
- Reset pulse while o_win_valid = 1 → o_win_valid = 0 next clk; the next accepted pixel is (0,0) without i_sof.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared helpers for the KxK sliding-window generator:
// counter widths, window element offsets and geometry legality.
package vp_pkg;

    // Counter width for a range of n values, never below one bit.
    function automatic int vp_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Window edge must be odd in 3..7 and fit inside one row.
    function automatic bit vp_k_legal(input int k, input int rl);
        return (k % 2 == 1) && (k >= 3) && (k <= 7) && (rl >= k);
    endfunction

    // LSB of window element (i,j): row i (0 = oldest), column j (0 = oldest).
    function automatic int vp_win_lsb(input int i, input int j,
                                      input int k, input int dw);
        return (i * k + j) * dw;
    endfunction

endpackage

// File: rtl/vp_line_ram.sv
// One row of pixel history: RL x DW, synchronous write,
// combinational read so a same-cycle read sees the old contents.
module vp_line_ram #(
    parameter int DW = 12,
    parameter int RL = 640,
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem_q [RL];

    // Storage is deliberately not reset; row gating hides stale data.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/vp_window_gen.sv
// KxK sliding-window generator with valid/ready on both sides,
// start-of-frame resync and end-of-row marking.
module vp_window_gen
    import vp_pkg::*;
#(
    parameter int DW = 12,
    parameter int RL = 640,
    parameter int K  = 3
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [DW-1:0]     i_pixel_data,
    input  logic              i_pixel_valid,
    input  logic              i_sof,
    output logic              o_pixel_ready,
    output logic [K*K*DW-1:0] o_win_data,
    output logic              o_win_valid,
    output logic              o_win_last,
    input  logic              i_win_ready
);

    localparam int CW = vp_width(RL);
    localparam int RW = vp_width(K);
    localparam int WW = K * K * DW;
    localparam int NL = K - 1;

    localparam logic [CW-1:0] COL_MAX = CW'(RL - 1);
    localparam logic [CW-1:0] COL_WIN = CW'(K - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(K - 1);

    if (!vp_k_legal(K, RL)) begin : g_bad_geometry
        $error("vp_window_gen: K must be odd in 3..7 and RL >= K");
    end

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [WW-1:0] win_q, win_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;

    logic          accept;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;
    logic          win_full;

    logic [DW-1:0] lb_rd [NL];
    logic [DW-1:0] lb_wd [NL];

    assign o_pixel_ready = !valid_q || i_win_ready;
    assign accept        = i_pixel_valid && o_pixel_ready;

    // A start-of-frame pixel is always (0,0), even mid-row.
    assign pos_col  = i_sof ? '0 : col_q;
    assign pos_row  = i_sof ? '0 : row_q;
    assign win_full = (pos_row == ROW_MAX) && (pos_col >= COL_WIN);

    // Line n holds the row n+1 above the current one; each accept
    // pushes the column's pixels one line further down the chain.
    for (genvar n = 0; n < NL; n++) begin : g_lb
        if (n == 0) begin : g_head
            assign lb_wd[n] = i_pixel_data;
        end else begin : g_tail
            assign lb_wd[n] = lb_rd[n-1];
        end
        vp_line_ram #(
            .DW (DW),
            .RL (RL),
            .AW (CW)
        ) u_ram (
            .i_clk   (i_clk),
            .i_we    (accept),
            .i_addr  (pos_col),
            .i_wdata (lb_wd[n]),
            .o_rdata (lb_rd[n])
        );
    end

    // Column wraps at end of row; row saturates once K rows are seen.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (i_sof) begin
                col_d = CW'(1);
                row_d = '0;
            end else if (col_q == COL_MAX) begin
                col_d = '0;
                if (row_q != ROW_MAX) begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Shift every window row one column older, load the new column.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_d[vp_win_lsb(i, j, K, DW) +: DW] =
                        win_q[vp_win_lsb(i, j + 1, K, DW) +: DW];
                end
            end
            win_d[vp_win_lsb(K - 1, K - 1, K, DW) +: DW] = i_pixel_data;
            for (int n = 0; n < NL; n++) begin
                win_d[vp_win_lsb(K - 2 - n, K - 1, K, DW) +: DW] = lb_rd[n];
            end
        end
    end

    // Window is valid only after a fully populated accept; a consumed
    // window with nothing new behind it is retired.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        if (accept) begin
            valid_d = win_full;
            last_d  = win_full && (pos_col == COL_MAX);
        end else if (i_win_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign o_win_data  = win_q;
    assign o_win_valid = valid_q;
    assign o_win_last  = last_q;

endmodule

// File: tb/tb_vp_window_gen.sv
// Bench for vp_window_gen: two geometries driven side by side,
// each checked against an image-based model of valid convolution.
module tb_vp_window_gen;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag,
                            input logic [255:0] obs,
                            input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int K  = (g == 0) ? 3 : 5;
        localparam int RL = (g == 0) ? 8 : 16;
        localparam int DW = (g == 0) ? 12 : 8;
        localparam int WW = K * K * DW;

        logic          rstn = 1'b0;
        logic          pv   = 1'b0;
        logic          sof  = 1'b0;
        logic          wr   = 1'b0;
        logic [DW-1:0] pd   = '0;
        logic          pr, wv, wl;
        logic [WW-1:0] wd;

        vp_window_gen #(
            .DW (DW),
            .RL (RL),
            .K  (K)
        ) dut (
            .i_clk         (clk),
            .i_rstn        (rstn),
            .i_pixel_data  (pd),
            .i_pixel_valid (pv),
            .i_sof         (sof),
            .o_pixel_ready (pr),
            .o_win_data    (wd),
            .o_win_valid   (wv),
            .o_win_last    (wl),
            .i_win_ready   (wr)
        );

        // Image seen so far (ring of 16 rows) and the window that
        // should currently be on the output.
        logic [DW-1:0] img [16][RL];
        logic [WW-1:0] e_data  = '0;
        logic          e_valid = 1'b0;
        logic          e_last  = 1'b0;
        logic          e_known = 1'b0;
        logic          live    = 1'b0;
        logic          done    = 1'b0;
        int            r = 0;
        int            c = 0;
        int            cnt = 0;

        task automatic step(input logic rn, input logic v,
                            input logic [DW-1:0] d, input logic s,
                            input logic w);
            @(negedge clk);
            rstn = rn;
            pv   = v;
            pd   = d;
            sof  = s;
            wr   = w;
            #1;
            if (live) begin
                check_eq("pix_ready", 256'(pr), 256'(!e_valid || w));
                check_eq("win_valid", 256'(wv), 256'(e_valid));
                if (e_valid) check_eq("win_last", 256'(wl), 256'(e_last));
                if (e_known) check_eq("win_data", 256'(wd), 256'(e_data));
                if (rn && wv && w) begin
                    cnt++;
                    if (wl) begin
                        check_eq("win_per_row", 256'(cnt), 256'(RL - K + 1));
                        cnt = 0;
                    end
                end
            end
            live = 1'b1;
            if (!rn) begin
                e_valid = 1'b0;
                e_last  = 1'b0;
                e_data  = '0;
                e_known = 1'b1;
                r = 0;
                c = 0;
                cnt = 0;
            end else if (v && (!e_valid || w)) begin
                if (s) begin
                    r = 0;
                    c = 0;
                    cnt = 0;
                end
                img[r % 16][c] = d;
                if (r >= K - 1 && c >= K - 1) begin
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            e_data[(i * K + j) * DW +: DW] =
                                img[(r - K + 1 + i) % 16][c - K + 1 + j];
                    e_valid = 1'b1;
                    e_last  = (c == RL - 1);
                    e_known = 1'b1;
                end else begin
                    e_valid = 1'b0;
                    e_last  = 1'b0;
                    e_known = 1'b0;
                end
                c++;
                if (c == RL) begin
                    c = 0;
                    r++;
                end
            end else if (w) begin
                e_valid = 1'b0;
                e_last  = 1'b0;
            end
        endtask

        initial begin
            repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
            // Frame 1: pixel = 16*row+col, stall 5 clks mid-row K.
            for (int y = 0; y < K + 1; y++) begin
                for (int x = 0; x < RL; x++) begin
                    if (y == K && x == K + 1)
                        repeat (5) step(1'b1, 1'b1, DW'(16 * y + x), 1'b0, 1'b0);
                    step(1'b1, 1'b1, DW'(16 * y + x), y == 0 && x == 0, 1'b1);
                end
            end
            for (int x = 0; x < 3; x++)
                step(1'b1, 1'b1, DW'(16 * (K + 1) + x), 1'b0, 1'b1);
            // Frame 2 restarts mid-row with unrelated pixel values.
            for (int y = 0; y < K + 1; y++)
                for (int x = 0; x < RL; x++)
                    step(1'b1, 1'b1, DW'($urandom), y == 0 && x == 0, 1'b1);
            // Random gaps, backpressure, rare sof and one reset pulse.
            for (int n = 0; n < 1500; n++) begin
                if (n == 700) begin
                    for (int t = 0; t < 50 && !e_valid; t++)
                        step(1'b1, 1'b1, DW'($urandom), 1'b0, 1'b1);
                    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
                end
                step(1'b1, $urandom_range(0, 9) < 7, DW'($urandom),
                     $urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7);
            end
            repeat (2) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
            done = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 40000 && !(cfg[0].done && cfg[1].done); t++)
            @(posedge clk);
        if (!(cfg[0].done && cfg[1].done))
            check_eq("timeout", 256'(0), 256'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
